// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and frame geometry.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_cksum.sv
// XOR accumulator for the payload checksum; clear takes priority over enable.
module imem_loader_cksum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   // Next running checksum
   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (en) begin
         sum_d = sum_q ^ din;
      end
   end

   // Checksum register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses LEN_HI/LEN_LO/payload/CHK byte frames, writes
// the payload byte-by-byte into instruction memory and holds the CPU until a good load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam logic [17:0] MEM_BYTES_18 = 18'(MEM_BYTES);
   localparam logic [17:0] BPW_18       = 18'(BYTES_PER_WORD);

   state_e              state_q, state_d;
   logic [15:0]         wc_q, wc_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;

   logic                xfer;
   logic                ck_clr;
   logic                ck_en;
   logic [7:0]          ck_sum;
   logic [15:0]         hdr_n;
   logic [17:0]         hdr_bytes;
   logic [17:0]         total_bytes;
   logic [17:0]         cnt_next_18;

   imem_loader_cksum u_cksum (
      .clk (CLK),
      .rst (RESET),
      .clr (ck_clr),
      .en  (ck_en),
      .din (rx_data),
      .sum (ck_sum)
   );

   // Stream acceptance is purely a function of the current state
   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: rx_ready = 1'b1;
         default:                                  rx_ready = 1'b0;
      endcase
   end

   assign xfer = rx_valid & rx_ready;

   // Length arithmetic: incoming header, latched frame size and post-increment byte count
   always_comb begin
      hdr_n       = {wc_q[15:8], rx_data};
      hdr_bytes   = 18'(hdr_n) * BPW_18;
      total_bytes = 18'(wc_q) * BPW_18;
      cnt_next_18 = 18'(cnt_q) + 18'd1;
   end

   // Next-state, counters, write port and checksum control
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ck_clr  = 1'b0;
      ck_en   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               cnt_d   = '0;
               ck_clr  = 1'b1;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               wc_d[15:8] = rx_data;
               state_d    = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (xfer) begin
               wc_d[7:0] = rx_data;
               if (hdr_bytes > MEM_BYTES_18) begin
                  state_d = ST_ERR;
               end else if (hdr_n == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = rx_data;
               cnt_d   = cnt_q + 1'b1;
               ck_en   = 1'b1;
               if (cnt_next_18 == total_bytes) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (xfer) begin
               state_d = (rx_data == ck_sum) ? ST_DONE : ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter and write-port registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         wc_q    <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_count = wc_q;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);
   assign cpu_hold   = (state_q != ST_DONE);

endmodule
